// File: rtl/inst_encoder_pkg.sv
// rtl/inst_encoder_pkg.sv - shared opcodes, formats, immediate limits and field bundle for inst_encoder
// Contents:
//   OP_*            RV32I major opcodes, instruction bits [6:2]
//   fmt_e           encoding format selected by the opcode
//   *_MIN / *_MAX   signed immediate limits per format
//   fields_t        the registered input bundle held in stage 1
//   fmt_of()        opcode -> format lookup
//   in_range()      signed inclusive range test

package inst_encoder_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_R_I    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_R_R    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    // funct3 values of the immediate shifts, which carry funct7 plus a 5-bit shamt
    localparam logic [2:0] F3_SLLI      = 3'b001;
    localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } fmt_e;

    localparam logic signed [31:0] I_MIN     = -32'sd2048;
    localparam logic signed [31:0] I_MAX     =  32'sd2047;
    localparam logic signed [31:0] B_MIN     = -32'sd4096;
    localparam logic signed [31:0] B_MAX     =  32'sd4094;
    localparam logic signed [31:0] J_MIN     = -32'sd1048576;
    localparam logic signed [31:0] J_MAX     =  32'sd1048574;
    localparam logic        [31:0] SHAMT_MAX =  32'd31;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    function automatic fmt_e fmt_of(input logic [4:0] op);
        fmt_e f;
        case (op)
            OP_R_R:                   f = FMT_R;
            OP_R_I, OP_LOAD, OP_JALR: f = FMT_I;
            OP_STORE:                 f = FMT_S;
            OP_BRANCH:                f = FMT_B;
            OP_LUI, OP_AUIPC:         f = FMT_U;
            OP_JAL:                   f = FMT_J;
            default:                  f = FMT_NONE;
        endcase
        return f;
    endfunction

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/inst_pack.sv
// rtl/inst_pack.sv - combinational RV32I field packing and immediate range check
// Ports:
//   opcode, rd, rs1, rs2, funct3, funct7, imm   in   stage-1 field bundle
//   inst                                        out  encoded instruction (truncated fields on error)
//   err                                         out  immediate not representable or opcode unsupported

module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    logic signed [31:0] simm;
    fmt_e               fmt;
    logic               is_shift;

    assign simm     = $signed(imm);
    assign fmt      = fmt_of(opcode);
    assign is_shift = (opcode == OP_R_I) && ((funct3 == F3_SLLI) || (funct3 == F3_SRLI_SRAI));

    always_comb begin
        inst = 32'h0;
        err  = 1'b0;
        case (fmt)
            FMT_R: begin
                inst = {funct7, rs2, rs1, funct3, rd, opcode, 2'b11};
            end
            FMT_I: begin
                if (is_shift) begin
                    // shamt is an unsigned 5-bit field; negative values are out of range too
                    inst = {funct7, imm[4:0], rs1, funct3, rd, opcode, 2'b11};
                    err  = (imm > SHAMT_MAX);
                end else begin
                    inst = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
                    err  = !in_range(simm, I_MIN, I_MAX);
                end
            end
            FMT_S: begin
                inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode, 2'b11};
                err  = !in_range(simm, I_MIN, I_MAX);
            end
            FMT_B: begin
                inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode, 2'b11};
                err  = imm[0] || !in_range(simm, B_MIN, B_MAX);
            end
            FMT_U: begin
                inst = {imm[31:12], rd, opcode, 2'b11};
                err  = (imm[11:0] != 12'h0);
            end
            FMT_J: begin
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11};
                err  = imm[0] || !in_range(simm, J_MIN, J_MAX);
            end
            default: begin
                inst = 32'h0;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - two-stage valid/ready RV32I instruction encoder with error counter
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       input handshake for the field bundle
//   opcode, rd, rs1, rs2,
//   funct3, funct7, imm       instruction fields
//   out_valid / out_ready     output handshake
//   inst, inst_err            encoded instruction and its error flag
//   err_cnt                   saturating count of errored instructions delivered

module inst_encoder
    import inst_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic        inst_err,
    output logic [15:0] err_cnt
);

    fields_t     s1_q;
    logic        s1_valid;
    logic        s1_adv;
    logic [31:0] pk_inst;
    logic        pk_err;

    // Stage 1 may move forward whenever stage 2 is empty or is being drained this cycle.
    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s1_adv);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                          funct3: funct3, funct7: funct7, imm: imm};
            end
        end
    end

    inst_pack u_pack (
        .opcode (s1_q.opcode),
        .rd     (s1_q.rd),
        .rs1    (s1_q.rs1),
        .rs2    (s1_q.rs2),
        .funct3 (s1_q.funct3),
        .funct7 (s1_q.funct7),
        .imm    (s1_q.imm),
        .inst   (pk_inst),
        .err    (pk_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            inst      <= 32'h0;
            inst_err  <= 1'b0;
            err_cnt   <= 16'h0;
        end else begin
            // While stalled (out_valid && !out_ready) s1_adv is low, so the output holds.
            if (s1_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    inst     <= pk_inst;
                    inst_err <= pk_err;
                end
            end
            if (out_valid && out_ready && inst_err && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard testbench for inst_encoder

module tb_inst_encoder;

    localparam logic [4:0] T_LOAD   = 5'b00000;
    localparam logic [4:0] T_R_I    = 5'b00100;
    localparam logic [4:0] T_AUIPC  = 5'b00101;
    localparam logic [4:0] T_STORE  = 5'b01000;
    localparam logic [4:0] T_R_R    = 5'b01100;
    localparam logic [4:0] T_LUI    = 5'b01101;
    localparam logic [4:0] T_BRANCH = 5'b11000;
    localparam logic [4:0] T_JALR   = 5'b11001;
    localparam logic [4:0] T_JAL    = 5'b11011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] inst;
    logic        inst_err;
    logic [15:0] err_cnt;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_err_cnt = 16'h0;
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    int          obs_cyc_q[$];

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] im;
        logic [31:0] ei;
        logic        ee;
    } vec_t;

    inst_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .inst_err  (inst_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back({inst_err, inst});
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic send(input vec_t v);
        int n;
        opcode = v.op; rd = v.d; rs1 = v.s1; rs2 = v.s2;
        funct3 = v.f3; funct7 = v.f7; imm = v.im; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_accept in_ready=%b required 1", in_ready);
        end else begin
            exp_q.push_back({v.ee, v.ei});
            if (v.ee && exp_err_cnt != 16'hFFFF) exp_err_cnt++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (inst !== 32'h0 || inst_err !== 1'b0) begin errors++; $display("FAIL reset_inst got=%h/%b want=0/0", inst, inst_err); end
        checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt got=%h want=0", err_cnt); end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_output got=%b want=0", out_valid); end
    endtask

    task automatic test_r_i_latency();
        logic [32:0] e, o;
        bit ok;
        opcode = T_R_I; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0;
        imm = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ri_in_ready got=%b want=1", in_ready); end
        exp_q.push_back({1'b0, 32'hFFF00093});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ri_latency_early out_valid=%b want=0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ri_latency out_valid=%b want=1", out_valid); end
        wait_outputs(exp_q.size(), ok);
        if (!ok) begin checks++; errors++; $display("FAIL ri_timeout got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL ri_inst got=%h err=%b want=%h err=%b", o[31:0], o[32], e[31:0], e[32]); end
        end
        checks++; if (err_cnt !== exp_err_cnt) begin errors++; $display("FAIL ri_err_cnt got=%0d want=%0d", err_cnt, exp_err_cnt); end
    endtask

    task automatic test_branch();
        logic [32:0] e, o;
        bit ok;
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL br_err_cnt_before got=%0d want=0", err_cnt); end
        send('{T_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd8, 32'hFE000CE3, 1'b0});
        send('{T_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00000163, 1'b1});
        wait_outputs(exp_q.size(), ok);
        if (!ok) begin checks++; errors++; $display("FAIL br_timeout got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL br_inst got=%h err=%b want=%h err=%b", o[31:0], o[32], e[31:0], e[32]); end
        end
        @(posedge clk); #1;
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL br_err_cnt got=%0d want=1", err_cnt); end
    endtask

    task automatic test_jal_lui();
        logic [32:0] e, o;
        bit ok;
        send('{T_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000EF, 1'b0});
        send('{T_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0});
        wait_outputs(exp_q.size(), ok);
        if (!ok) begin checks++; errors++; $display("FAIL jl_timeout got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL jl_inst got=%h err=%b want=%h err=%b", o[31:0], o[32], e[31:0], e[32]); end
        end
    endtask

    task automatic test_boundaries();
        logic [32:0] e, o;
        bit ok;
        vec_t tbl[19];
        tbl = '{
            '{T_R_I,    5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,       32'h7FF00013, 1'b0},
            '{T_R_I,    5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h80000013, 1'b1},
            '{T_R_I,    5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800,   32'h80000013, 1'b0},
            '{T_R_I,    5'd2, 5'd3, 5'd0, 3'd1, 7'h00, 32'd31,         32'h01F19113, 1'b0},
            '{T_R_I,    5'd0, 5'd0, 5'd0, 3'd5, 7'h20, 32'd32,         32'h40005013, 1'b1},
            '{T_R_R,    5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF,   32'h002081B3, 1'b0},
            '{T_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFFFFC,   32'hFE20AE23, 1'b0},
            '{T_STORE,  5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h80000023, 1'b1},
            '{T_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,       32'h7E000FE3, 1'b0},
            '{T_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,       32'h80000063, 1'b1},
            '{T_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000,   32'h80000063, 1'b0},
            '{T_AUIPC,  5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001001,   32'h00001017, 1'b1},
            '{T_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048576,    32'h8000006F, 1'b1},
            '{T_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048574,    32'h7FFFF06F, 1'b0},
            '{T_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000,   32'h8000006F, 1'b0},
            '{T_JALR,   5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'd0,          32'h00008067, 1'b0},
            '{T_LOAD,   5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 32'd8,          32'h00812283, 1'b0},
            '{5'b11111, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'd0,          32'h00000000, 1'b1},
            '{5'b00011, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'd0,          32'h00000000, 1'b1}
        };
        foreach (tbl[i]) send(tbl[i]);
        wait_outputs(exp_q.size(), ok);
        if (!ok) begin checks++; errors++; $display("FAIL bnd_timeout got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL bnd_inst got=%h err=%b want=%h err=%b", o[31:0], o[32], e[31:0], e[32]); end
        end
        @(posedge clk); #1;
        checks++; if (err_cnt !== exp_err_cnt) begin errors++; $display("FAIL bnd_err_cnt got=%0d want=%0d", err_cnt, exp_err_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e, o;
        bit ok;
        obs_q.delete(); obs_cyc_q.delete();
        for (int k = 4; k < 8; k++) begin
            send('{T_R_R, k[4:0], 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h00208033 | (k << 7), 1'b0});
        end
        wait_outputs(4, ok);
        if (!ok) begin
            checks++; errors++; $display("FAIL b2b_timeout got=%0d want=4", obs_q.size());
        end else begin
            checks++;
            if (obs_cyc_q[3] - obs_cyc_q[0] != 3) begin
                errors++; $display("FAIL b2b_throughput span=%0d want=3", obs_cyc_q[3] - obs_cyc_q[0]);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_inst got=%h err=%b want=%h err=%b", o[31:0], o[32], e[31:0], e[32]); end
        end
        obs_cyc_q.delete();
    endtask

    task automatic test_stall();
        logic [32:0] e, o;
        logic [31:0] held;
        logic        held_v;
        bit          ok;
        int          idx;
        vec_t        b[3];
        b[0] = '{T_R_R, 5'd1, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002080B3, 1'b0};
        b[1] = '{T_R_R, 5'd2, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h00208133, 1'b0};
        b[2] = '{T_R_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 1'b0};
        idx = 0; held_v = 1'b0; held = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            opcode = b[idx].op; rd = b[idx].d; rs1 = b[idx].s1; rs2 = b[idx].s2;
            funct3 = b[idx].f3; funct7 = b[idx].f7; imm = b[idx].im; in_valid = 1'b1;
            @(negedge clk);
            if (out_valid) begin
                if (held_v) begin
                    checks++;
                    if (inst !== held) begin errors++; $display("FAIL stall_hold got=%h want=%h", inst, held); end
                end
                held = inst; held_v = 1'b1;
            end
            if (in_ready) begin
                exp_q.push_back({b[idx].ee, b[idx].ei});
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (idx != 2) begin errors++; $display("FAIL stall_accepted got=%0d want=2", idx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || inst !== 32'h002080B3) begin errors++; $display("FAIL stall_out got=%b/%h want=1/002080b3", out_valid, inst); end
        out_ready = 1'b1;
        send(b[2]);
        wait_outputs(3, ok);
        if (!ok) begin checks++; errors++; $display("FAIL stall_timeout got=%0d want=3", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL stall_order got=%h err=%b want=%h err=%b", o[31:0], o[32], e[31:0], e[32]); end
        end
    endtask

    task automatic test_reset_midstall();
        logic [32:0] e, o;
        bit ok;
        out_ready = 1'b0;
        send('{T_R_R, 5'd8, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h00208433, 1'b0});
        send('{T_R_I, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5000, 32'h38800013, 1'b1});
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rstm_full out_valid=%b in_ready=%b want=1/0", out_valid, in_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        opcode = T_R_R; rd = 5'd9; rs1 = 5'd1; rs2 = 5'd2; funct3 = 3'd0; funct7 = 7'h00; imm = 32'd0;
        in_valid = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstm_in_ready_rst got=%b want=0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_err_cnt = 16'h0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_out_valid got=%b want=0", out_valid); end
        checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL rstm_err_cnt got=%0d want=0", err_cnt); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstm_in_ready_after got=%b want=1", in_ready); end
        if (in_ready) exp_q.push_back({1'b0, 32'h002084B3});
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_outputs(1, ok);
        if (!ok) begin checks++; errors++; $display("FAIL rstm_timeout got=%0d want=1", obs_q.size()); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL rstm_stale got=%0d outputs want=1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL rstm_inst got=%h err=%b want=%h err=%b", o[31:0], o[32], e[31:0], e[32]); end
        end
        checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL rstm_err_cnt_end got=%0d want=0", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_r_i_latency();
        test_branch();
        test_jal_lui();
        test_boundaries();
        test_back_to_back();
        test_stall();
        test_reset_midstall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1, the field bundle below is valid.
REQ-004 SHALL have port in_ready, output, 1, encoder accepts the bundle this cycle.
REQ-005 SHALL have port opcode, input, 5, instruction bits [6:2] (R_R, R_I, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL).
REQ-006 SHALL have ports rd, rs1 and rs2, input, 5 each, register indices.
REQ-007 SHALL have ports funct3, input, 3, and funct7, input, 7, function fields.
REQ-008 SHALL have port imm, input, 32, signed byte-offset or value immediate.
REQ-009 SHALL have port out_valid, output, 1, inst and inst_err are valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the output.
REQ-011 SHALL have port inst, output, 32, encoded RV32I instruction.
REQ-012 SHALL have port inst_err, output, 1, immediate not representable or opcode unsupported.
REQ-013 SHALL have port err_cnt, output, 16, saturating count of transferred errored instructions.

Function
REQ-014 SHALL implement a 2-stage pipeline: S1 registers the accepted fields; S2 registers the encoded inst and inst_err.
REQ-015 SHALL complete a transfer on in_valid&&in_ready and on out_valid&&out_ready; with out_ready held high, latency is 2 cycles and throughput 1/cycle.
REQ-016 SHALL drive in_ready = !rst && (!s1_valid || S1 advancing); S1 advances when !s2_valid || out_ready.
REQ-017 SHALL hold inst, inst_err and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL always set inst[1:0]=2'b11 and inst[6:2]=opcode for supported opcodes.
REQ-019 R_R: {funct7,rs2,rs1,funct3,rd}; imm ignored; err=0.
REQ-020 R_I/LOAD/JALR: inst[31:20]=imm[11:0]; err if imm outside [-2048,2047].
REQ-021 R_I with funct3 001/101: inst[31:25]=funct7, inst[24:20]=imm[4:0]; err if imm unsigned > 31.
REQ-022 STORE: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; err if outside [-2048,2047].
REQ-023 BRANCH: inst[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; err if imm[0]=1 or outside [-4096,4094].
REQ-024 LUI/AUIPC: inst[31:12]=imm[31:12]; err if imm[11:0]!=0.
REQ-025 JAL: inst[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; err if imm[0]=1 or outside [-1048576,1048574].
REQ-026 SHALL, for an unsupported opcode, output inst=32'h0 and inst_err=1.
REQ-027 SHALL, on err for a supported opcode, still output the truncated-field encoding.
REQ-028 SHALL increment err_cnt on each output transfer with inst_err=1, saturating at 16'hFFFF.

Reset
REQ-029 SHALL on rst clear s1_valid, out_valid, inst, inst_err and err_cnt to 0, discarding in-flight entries, including mid-stall.
REQ-030 SHALL accept no input during a rst cycle and allow acceptance on the first cycle after.

Structure
REQ-031 SHALL take the opcode constants from the shared define set, and SHALL place the format enum (R, I, S, B, U, J) and the range limits in a shared package.
REQ-032 SHALL put the combinational field packing and range checking in a sub-module inst_pack, instantiated between S1 and S2.

Verification
REQ-033 Bench SHALL cover: R_I, rd=1, rs1=0, funct3=0, imm=-1 -> inst=32'hFFF00093, err=0, two cycles after acceptance.
REQ-034 Bench SHALL cover: BRANCH, rs1=rs2=0, funct3=0, imm=-8 -> 32'hFE000CE3; imm=3 -> inst_err=1 and err_cnt 0->1.
REQ-035 Bench SHALL cover: JAL, rd=1, imm=2048 -> 32'h001000EF; LUI, rd=5, imm=32'h12345000 -> 32'h123452B7.
REQ-036 Bench SHALL cover: out_ready low 4 cycles while 3 bundles are offered -> in_ready falls after 2 accepted, inst held stable, all 3 delivered in order.
REQ-037 Bench SHALL cover: rst pulsed while S1 and S2 are full and stalled -> next cycle out_valid=0 and err_cnt=0, and no stale instruction ever emitted.
